// File: rtl/vx_stream_pkt_arb.sv
// Packet-aware N-to-M round-robin stream arbiter: a grant is held from first beat to `last`.
// Optional per-output perf counters are compiled in with `define STREAM_PKT_ARB_PERF_EN.
module vx_stream_pkt_arb #(
    parameter int  NUM_INPUTS  = 4,
    parameter int  NUM_OUTPUTS = 1,
    parameter int  DATAW       = 32,
    parameter int  OUT_BUF     = 0,
    parameter int  PERF_CTR_W  = 32,
    localparam int NUM_REQS    = (NUM_INPUTS + NUM_OUTPUTS - 1) / NUM_OUTPUTS,
    localparam int NUM_REQS_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_INPUTS-1:0]             valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0]       data_in,
    input  logic [NUM_INPUTS-1:0]             last_in,
    output logic [NUM_INPUTS-1:0]             ready_in,
    output logic [NUM_OUTPUTS-1:0]            valid_out,
    output logic [NUM_OUTPUTS*DATAW-1:0]      data_out,
    output logic [NUM_OUTPUTS-1:0]            last_out,
    output logic [NUM_OUTPUTS*NUM_REQS_W-1:0] sel_out,
    input  logic [NUM_OUTPUTS-1:0]            ready_out
`ifdef STREAM_PKT_ARB_PERF_EN
    ,
    output logic [NUM_OUTPUTS*PERF_CTR_W-1:0] perf_pkts_out,
    output logic [NUM_OUTPUTS*PERF_CTR_W-1:0] perf_stalls
`endif
);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    if (NUM_OUTPUTS < 1 || NUM_INPUTS < NUM_OUTPUTS || DATAW < 1 || PERF_CTR_W < 1
        || (OUT_BUF != 0 && OUT_BUF != 1)) begin : g_bad_cfg
        $error("vx_stream_pkt_arb: unsupported parameter combination");
    end

    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_grp
        localparam int BASE  = gi * NUM_REQS;
        localparam int AVAIL = NUM_INPUTS - BASE;
        localparam int GS    = (AVAIL >= NUM_REQS) ? NUM_REQS : ((AVAIL > 0) ? AVAIL : 0);

        logic                  out_valid;
        logic                  out_last;
        logic [DATAW-1:0]      out_data;
        logic [NUM_REQS_W-1:0] out_sel;

        if (GS == 0) begin : g_empty
            // Ceiling division can leave trailing outputs with no inputs at all.
            assign out_valid = 1'b0;
            assign out_last  = 1'b0;
            assign out_data  = '0;
            assign out_sel   = '0;
        end else begin : g_arb
            logic [NUM_REQS-1:0]   req_valid;
            logic [NUM_REQS-1:0]   req_last;
            logic [DATAW-1:0]      req_data [NUM_REQS];
            state_t                state_reg, state_next;
            logic [NUM_REQS_W-1:0] rr_ptr_reg, rr_ptr_next;
            logic [NUM_REQS_W-1:0] lock_idx_reg, lock_idx_next;
            logic [NUM_REQS_W-1:0] grant;
            logic                  found;
            logic                  arb_valid;
            logic                  arb_last;
            logic [DATAW-1:0]      arb_data;
            logic                  stage_ready;
            logic                  fire;

            function automatic logic [NUM_REQS_W-1:0] ptr_inc(input logic [NUM_REQS_W-1:0] p);
                return (int'(p) >= GS - 1) ? '0 : p + 1'b1;
            endfunction

            for (genvar ri = 0; ri < NUM_REQS; ri++) begin : g_req
                if (ri < GS) begin : g_on
                    localparam logic [NUM_REQS_W-1:0] RI = NUM_REQS_W'(ri);
                    assign req_valid[ri] = valid_in[BASE+ri];
                    assign req_last[ri]  = last_in[BASE+ri];
                    assign req_data[ri]  = data_in[(BASE+ri)*DATAW +: DATAW];
                    assign ready_in[BASE+ri] = stage_ready && !reset &&
                        ((state_reg == ST_IDLE) ? (found && (grant == RI)) : (lock_idx_reg == RI));
                end else begin : g_pad
                    assign req_valid[ri] = 1'b0;
                    assign req_last[ri]  = 1'b0;
                    assign req_data[ri]  = '0;
                end
            end

            always_comb begin
                int                    cand;
                logic [NUM_REQS_W-1:0] cand_idx;
                cand     = 0;
                cand_idx = '0;
                grant    = lock_idx_reg;
                found    = 1'b0;
                if (state_reg == ST_IDLE) begin
                    // Walk downwards so the valid candidate closest to rr_ptr wins.
                    for (int k = GS - 1; k >= 0; k--) begin
                        cand = int'(rr_ptr_reg) + k;
                        if (cand >= GS) cand = cand - GS;
                        cand_idx = NUM_REQS_W'(cand);
                        if (req_valid[cand_idx]) begin
                            grant = cand_idx;
                            found = 1'b1;
                        end
                    end
                end
            end

            assign arb_valid = (state_reg == ST_IDLE) ? found : req_valid[lock_idx_reg];
            assign arb_last  = req_last[grant];
            assign arb_data  = req_data[grant];
            assign fire      = arb_valid && stage_ready && !reset;

            always_comb begin
                state_next    = state_reg;
                rr_ptr_next   = rr_ptr_reg;
                lock_idx_next = lock_idx_reg;
                if (fire) begin
                    if (state_reg == ST_IDLE) begin
                        if (arb_last) begin
                            rr_ptr_next = ptr_inc(grant);
                        end else begin
                            lock_idx_next = grant;
                            state_next    = ST_LOCKED;
                        end
                    end else if (arb_last) begin
                        state_next  = ST_IDLE;
                        rr_ptr_next = ptr_inc(lock_idx_reg);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg    <= ST_IDLE;
                    rr_ptr_reg   <= '0;
                    lock_idx_reg <= '0;
                end else begin
                    state_reg    <= state_next;
                    rr_ptr_reg   <= rr_ptr_next;
                    lock_idx_reg <= lock_idx_next;
                end
            end

            if (OUT_BUF == 0) begin : g_pass
                assign stage_ready = ready_out[gi];
                assign out_valid   = arb_valid && !reset;
                assign out_last    = arb_last;
                assign out_data    = arb_data;
                assign out_sel     = grant;
            end else begin : g_skid
                localparam int EW = NUM_REQS_W + 1 + DATAW;
                logic [EW-1:0] buf_mem [2];
                logic          wr_ptr_reg;
                logic          rd_ptr_reg;
                logic [1:0]    count_reg;
                logic          pop;

                // Accepting depends only on registered occupancy, never on ready_out.
                assign stage_ready = (count_reg != 2'd2);
                assign pop         = (count_reg != 2'd0) && ready_out[gi];

                always_ff @(posedge clk) begin
                    if (fire) buf_mem[wr_ptr_reg] <= {grant, arb_last, arb_data};
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        wr_ptr_reg <= 1'b0;
                        rd_ptr_reg <= 1'b0;
                        count_reg  <= 2'd0;
                    end else begin
                        if (fire) wr_ptr_reg <= !wr_ptr_reg;
                        if (pop)  rd_ptr_reg <= !rd_ptr_reg;
                        case ({fire, pop})
                            2'b10:   count_reg <= count_reg + 2'd1;
                            2'b01:   count_reg <= count_reg - 2'd1;
                            default: ;
                        endcase
                    end
                end

                assign {out_sel, out_last, out_data} = buf_mem[rd_ptr_reg];
                assign out_valid = (count_reg != 2'd0);
            end
        end

        assign valid_out[gi]                          = out_valid;
        assign last_out[gi]                           = out_last;
        assign data_out[gi*DATAW +: DATAW]            = out_data;
        assign sel_out[gi*NUM_REQS_W +: NUM_REQS_W]   = out_sel;

`ifdef STREAM_PKT_ARB_PERF_EN
        logic [PERF_CTR_W-1:0] pkts_reg;
        logic [PERF_CTR_W-1:0] stalls_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                pkts_reg   <= '0;
                stalls_reg <= '0;
            end else begin
                if (out_valid && ready_out[gi] && out_last) pkts_reg <= pkts_reg + 1'b1;
                if (out_valid && !ready_out[gi])            stalls_reg <= stalls_reg + 1'b1;
            end
        end

        assign perf_pkts_out[gi*PERF_CTR_W +: PERF_CTR_W] = pkts_reg;
        assign perf_stalls[gi*PERF_CTR_W +: PERF_CTR_W]   = stalls_reg;
`else
        // Counters are compiled out.
`endif
    end

endmodule

// File: tb/tb_vx_stream_pkt_arb.sv
// Directed bench for vx_stream_pkt_arb: 4:1 pass-through, 4:1 skid buffer and 6:2 grouping.
module tb_vx_stream_pkt_arb;
    localparam int DW = 8;
    localparam int PW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_bc;

    int n_cmp = 0;
    int n_err = 0;

    // 4:1, combinational output stage
    logic [3:0]      a_valid, a_last, a_ready_in;
    logic [4*DW-1:0] a_data;
    logic [0:0]      a_vout, a_lout, a_rout;
    logic [DW-1:0]   a_dout;
    logic [1:0]      a_sel;
    logic [PW-1:0]   a_pkts, a_stalls;

    // 4:1, skid buffer
    logic [3:0]      b_valid, b_last, b_ready_in;
    logic [4*DW-1:0] b_data;
    logic [0:0]      b_vout, b_lout, b_rout;
    logic [DW-1:0]   b_dout;
    logic [1:0]      b_sel;
    logic [PW-1:0]   b_pkts, b_stalls;

    // 6:2, two groups of three
    logic [5:0]      c_valid, c_last, c_ready_in;
    logic [6*DW-1:0] c_data;
    logic [1:0]      c_vout, c_lout, c_rout;
    logic [2*DW-1:0] c_dout;
    logic [3:0]      c_sel;
    logic [2*PW-1:0] c_pkts, c_stalls;

    vx_stream_pkt_arb #(.NUM_INPUTS(4), .NUM_OUTPUTS(1), .DATAW(DW), .OUT_BUF(0), .PERF_CTR_W(PW)) dut_a (
        .clk(clk), .reset(rst_a), .valid_in(a_valid), .data_in(a_data), .last_in(a_last),
        .ready_in(a_ready_in), .valid_out(a_vout), .data_out(a_dout), .last_out(a_lout),
        .sel_out(a_sel), .ready_out(a_rout)
`ifdef STREAM_PKT_ARB_PERF_EN
        , .perf_pkts_out(a_pkts), .perf_stalls(a_stalls)
`endif
    );

    vx_stream_pkt_arb #(.NUM_INPUTS(4), .NUM_OUTPUTS(1), .DATAW(DW), .OUT_BUF(1), .PERF_CTR_W(PW)) dut_b (
        .clk(clk), .reset(rst_bc), .valid_in(b_valid), .data_in(b_data), .last_in(b_last),
        .ready_in(b_ready_in), .valid_out(b_vout), .data_out(b_dout), .last_out(b_lout),
        .sel_out(b_sel), .ready_out(b_rout)
`ifdef STREAM_PKT_ARB_PERF_EN
        , .perf_pkts_out(b_pkts), .perf_stalls(b_stalls)
`endif
    );

    vx_stream_pkt_arb #(.NUM_INPUTS(6), .NUM_OUTPUTS(2), .DATAW(DW), .OUT_BUF(0), .PERF_CTR_W(PW)) dut_c (
        .clk(clk), .reset(rst_bc), .valid_in(c_valid), .data_in(c_data), .last_in(c_last),
        .ready_in(c_ready_in), .valid_out(c_vout), .data_out(c_dout), .last_out(c_lout),
        .sel_out(c_sel), .ready_out(c_rout)
`ifdef STREAM_PKT_ARB_PERF_EN
        , .perf_pkts_out(c_pkts), .perf_stalls(c_stalls)
`endif
    );

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // One cycle on dut_a: drive at negedge, check settled outputs 1ns later.
    task automatic cyc_a(input logic [3:0] v, input logic [3:0] l, input logic r, input logic rs,
                         input logic [3:0] tag, input logic vo, input logic [1:0] sel,
                         input logic lo, input logic [3:0] rin);
        @(negedge clk);
        rst_a   = rs;
        a_valid = v;
        a_last  = l;
        a_rout  = r;
        for (int i = 0; i < 4; i++) a_data[i*DW +: DW] = {tag, 4'(i)};
        #1;
        $display("a tag=%h rst=%b valid=%b ready_in=%b vout=%b sel=%0d last=%b data=%h",
                 tag, rs, v, a_ready_in, a_vout, a_sel, a_lout, a_dout);
        check_eq("a_valid_out", 32'(a_vout), 32'(vo));
        check_eq("a_ready_in", 32'(a_ready_in), 32'(rin));
        if (vo) begin
            check_eq("a_sel_out", 32'(a_sel), 32'(sel));
            check_eq("a_last_out", 32'(a_lout), 32'(lo));
            check_eq("a_data_out", 32'(a_dout), 32'({tag, 2'b00, sel}));
        end
    endtask

    // One cycle on dut_b: only input 2 offers beats, payload {B, beat}.
    task automatic cyc_b(input logic v, input logic [3:0] beat, input logic lst, input logic r,
                         input logic vo, input logic [3:0] dbeat, input logic lo,
                         input logic [3:0] rin);
        @(negedge clk);
        b_valid = v ? 4'b0100 : 4'b0000;
        b_last  = lst ? 4'b0100 : 4'b0000;
        b_rout  = r;
        for (int i = 0; i < 4; i++) b_data[i*DW +: DW] = {4'hB, beat};
        #1;
        $display("b beat=%0d valid=%b ready_out=%b ready_in=%b vout=%b sel=%0d last=%b data=%h",
                 beat, v, r, b_ready_in, b_vout, b_sel, b_lout, b_dout);
        check_eq("b_valid_out", 32'(b_vout), 32'(vo));
        check_eq("b_ready_in", 32'(b_ready_in), 32'(rin));
        if (vo) begin
            check_eq("b_data_out", 32'(b_dout), 32'({4'hB, dbeat}));
            check_eq("b_last_out", 32'(b_lout), 32'(lo));
            check_eq("b_sel_out", 32'(b_sel), 32'd2);
        end
    endtask

    task automatic drive_c(input logic [5:0] v, input logic [5:0] l, input logic [3:0] beat);
        @(negedge clk);
        c_valid = v;
        c_last  = l;
        c_rout  = 2'b11;
        for (int i = 0; i < 6; i++) c_data[i*DW +: DW] = {beat, 4'(i)};
        #1;
        $display("c beat=%0d valid=%b ready_in=%b vout=%b sel=%h last=%b data=%h",
                 beat, v, c_ready_in, c_vout, c_sel, c_lout, c_dout);
    endtask

    initial begin
        rst_a = 1'b1; rst_bc = 1'b1;
        a_valid = '0; a_last = '0; a_data = '0; a_rout = 1'b1;
        b_valid = '0; b_last = '0; b_data = '0; b_rout = 1'b1;
        c_valid = '0; c_last = '0; c_data = '0; c_rout = 2'b11;

        // Reset with all inputs requesting: nothing may be granted or forwarded.
        cyc_a(4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 4'b0000);
        cyc_a(4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 4'b0000);
        rst_bc = 1'b0;

        // Single-beat packets from all inputs: 0,1,2,3,0.
        cyc_a(4'hF, 4'hF, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 1'b1, 4'b0001);
`ifdef STREAM_PKT_ARB_PERF_EN
        check_eq("a_perf_pkts_rst", 32'(a_pkts), 32'd0);
        check_eq("a_perf_stalls_rst", 32'(a_stalls), 32'd0);
`endif
        cyc_a(4'hF, 4'hF, 1'b1, 1'b0, 4'h2, 1'b1, 2'd1, 1'b1, 4'b0010);
        cyc_a(4'hF, 4'hF, 1'b1, 1'b0, 4'h3, 1'b1, 2'd2, 1'b1, 4'b0100);
        cyc_a(4'hF, 4'hF, 1'b1, 1'b0, 4'h4, 1'b1, 2'd3, 1'b1, 4'b1000);
        cyc_a(4'hF, 4'hF, 1'b1, 1'b0, 4'h5, 1'b1, 2'd0, 1'b1, 4'b0001);

        // Input 1 sends three beats while 0 and 2 wait; then grant moves to 2.
        cyc_a(4'b0111, 4'b1101, 1'b1, 1'b0, 4'h6, 1'b1, 2'd1, 1'b0, 4'b0010);
        cyc_a(4'b0111, 4'b1101, 1'b1, 1'b0, 4'h7, 1'b1, 2'd1, 1'b0, 4'b0010);
        cyc_a(4'b0111, 4'b1111, 1'b1, 1'b0, 4'h8, 1'b1, 2'd1, 1'b1, 4'b0010);
        cyc_a(4'b0101, 4'b1111, 1'b1, 1'b0, 4'h9, 1'b1, 2'd2, 1'b1, 4'b0100);

        // Locked input 1 bubbles for two cycles, stalls once, then finishes.
        cyc_a(4'b0010, 4'b0000, 1'b1, 1'b0, 4'hA, 1'b1, 2'd1, 1'b0, 4'b0010);
        cyc_a(4'b0101, 4'b1111, 1'b1, 1'b0, 4'hB, 1'b0, 2'd0, 1'b0, 4'b0010);
        cyc_a(4'b0101, 4'b1111, 1'b1, 1'b0, 4'hC, 1'b0, 2'd0, 1'b0, 4'b0010);
        cyc_a(4'b0111, 4'b0000, 1'b0, 1'b0, 4'hD, 1'b1, 2'd1, 1'b0, 4'b0000);
        cyc_a(4'b0111, 4'b0000, 1'b1, 1'b0, 4'hE, 1'b1, 2'd1, 1'b0, 4'b0010);
        cyc_a(4'b0111, 4'b1111, 1'b1, 1'b0, 4'hF, 1'b1, 2'd1, 1'b1, 4'b0010);
        cyc_a(4'b0101, 4'b1111, 1'b1, 1'b0, 4'h1, 1'b1, 2'd2, 1'b1, 4'b0100);

        // Input 3 starts a 4-beat packet; reset lands on beat 2.
        cyc_a(4'b1000, 4'b0000, 1'b1, 1'b0, 4'h2, 1'b1, 2'd3, 1'b0, 4'b1000);
`ifdef STREAM_PKT_ARB_PERF_EN
        check_eq("a_perf_pkts", 32'(a_pkts), 32'd9);
        check_eq("a_perf_stalls", 32'(a_stalls), 32'd1);
`endif
        cyc_a(4'b1000, 4'b0000, 1'b1, 1'b1, 4'h3, 1'b0, 2'd0, 1'b0, 4'b0000);
        cyc_a(4'b1001, 4'b1111, 1'b1, 1'b0, 4'h4, 1'b1, 2'd0, 1'b1, 4'b0001);
`ifdef STREAM_PKT_ARB_PERF_EN
        check_eq("a_perf_pkts_midrst", 32'(a_pkts), 32'd0);
        check_eq("a_perf_stalls_midrst", 32'(a_stalls), 32'd0);
`endif
        cyc_a(4'b0000, 4'b0000, 1'b1, 1'b0, 4'h5, 1'b0, 2'd0, 1'b0, 4'b0000);
`ifdef STREAM_PKT_ARB_PERF_EN
        check_eq("a_perf_pkts_after", 32'(a_pkts), 32'd1);
`endif

        // Skid buffer, 4-beat stream from input 2 with ready_out toggling.
        cyc_b(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0100);
        cyc_b(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 4'b0100);
        cyc_b(1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 4'b0000);
        cyc_b(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 4'b0100);
        cyc_b(1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 4'b0000);
        cyc_b(1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 4'b0100);
        cyc_b(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 4'b0000);
        cyc_b(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 4'b0000);
        cyc_b(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 4'b0000);
        cyc_b(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0000);

        // Two groups forward 2-beat packets from inputs 0 and 3 concurrently.
        drive_c(6'b001011, 6'b000010, 4'd1);
        check_eq("c_valid_out_b1", 32'(c_vout), 32'b11);
        check_eq("c_sel_out_b1", 32'(c_sel), 32'h0);
        check_eq("c_last_out_b1", 32'(c_lout), 32'b00);
        check_eq("c_ready_in_b1", 32'(c_ready_in), 32'b001001);
        check_eq("c_data_out_b1", 32'(c_dout), 32'h1310);
        drive_c(6'b001011, 6'b001011, 4'd2);
        check_eq("c_valid_out_b2", 32'(c_vout), 32'b11);
        check_eq("c_sel_out_b2", 32'(c_sel), 32'h0);
        check_eq("c_last_out_b2", 32'(c_lout), 32'b11);
        check_eq("c_ready_in_b2", 32'(c_ready_in), 32'b001001);
        check_eq("c_data_out_b2", 32'(c_dout), 32'h2320);
        drive_c(6'b000010, 6'b000010, 4'd3);
        check_eq("c_valid_out_b3", 32'(c_vout), 32'b01);
        check_eq("c_ready_in_b3", 32'(c_ready_in), 32'b000010);
        check_eq("c_sel0_b3", 32'(c_sel[1:0]), 32'd1);
        check_eq("c_last0_b3", 32'(c_lout[0]), 32'd1);
        check_eq("c_data0_b3", 32'(c_dout[DW-1:0]), 32'h31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vx_stream_pkt_arb.md
# vx_stream_pkt_arb

Packet-aware N-to-M stream arbiter for the Vortex memory and interconnect fabric. It is the successor to the beat-level stream arbiter. Inputs are grouped onto outputs, and each group runs round-robin arbitration at packet granularity. A grant is locked from the first beat until the beat flagged `last`, so multi-beat bursts are never interleaved on an output. An optional per-output skid buffer decouples the output ready path.

## Interface
Parameters:
- NUM_INPUTS, 4, number of input streams; must be ≥ NUM_OUTPUTS
- NUM_OUTPUTS, 1, number of output streams
- DATAW, 32, payload width per beat
- OUT_BUF, 0, output stage: 0 = combinational pass-through, 1 = 2-entry skid buffer
- PERF_CTR_W, 32, width of performance counters (used only with the perf macro)
- NUM_REQS, CDIV(NUM_INPUTS, NUM_OUTPUTS), inputs per group (derived)
- NUM_REQS_W, UP(CLOG2(NUM_REQS)), width of the select index (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  NUM_INPUTS  per-input beat valid
- data_in  in  NUM_INPUTS×DATAW  per-input payload
- last_in  in  NUM_INPUTS  final beat of packet
- ready_in  out  NUM_INPUTS  per-input accept
- valid_out  out  NUM_OUTPUTS  output beat valid
- data_out  out  NUM_OUTPUTS×DATAW  output payload
- last_out  out  NUM_OUTPUTS  final beat of forwarded packet
- sel_out  out  NUM_OUTPUTS×NUM_REQS_W  local index of the source input within its group
- ready_out  in  NUM_OUTPUTS  downstream accept
- perf_pkts_out  out  NUM_OUTPUTS×PERF_CTR_W  packets completed per output (only with the perf macro)
- perf_stalls  out  NUM_OUTPUTS×PERF_CTR_W  backpressure cycles per output (only with the perf macro)

## Operation
- Input i belongs to group g = i / NUM_REQS, with local index i % NUM_REQS. The last group may be short.
- Each group has its own FSM, round-robin pointer `rr_ptr` and `lock_idx` register.
- IDLE state:
  - The group grants the first valid input at or after `rr_ptr`, searching cyclically.
  - Output valid equals the granted input's valid. data, last and sel come from the granted input.
  - ready_in is asserted only for the granted input, and only while the output stage is accepting.
- Handshake in IDLE with last=1 (single-beat packet): state stays IDLE and rr_ptr ← grant+1 mod group size.
- Handshake in IDLE with last=0: lock_idx ← grant and state → LOCKED.
- LOCKED state:
  - Only lock_idx is visible and may transfer. All other inputs in the group see ready_in=0.
  - Output valid follows valid_in[lock_idx], so bubbles inside a packet are passed through.
  - A handshake with last=1 moves state → IDLE and sets rr_ptr ← lock_idx+1.
- A group of size 1 degenerates to a pass-through with sel_out=0. The FSM still tracks lock state, but it has no effect.
- Upstream must hold valid, data and last stable until ready. A packet must not be withdrawn mid-stream.
- Skid buffer (OUT_BUF=1): 2 entries; the stage is accepting whenever it is not full. {sel, last, data} are buffered together.

## Timing
- Reset: valid_out=0, state=IDLE, rr_ptr=0, lock_idx=0, buffer empty, counters=0. ready_in=0 during reset.
- OUT_BUF=0: zero latency. ready_in depends combinationally on ready_out and valid_in.
- OUT_BUF=1: one-cycle latency and full throughput (1 beat/cycle under continuous ready). ready_in has no combinational path from ready_out.
- Back-to-back packets: on the cycle after the last-beat handshake, the FSM is in IDLE and arbitrates with no bubble. A new packet from a different input can transfer on that cycle.
- Simultaneous requests on the cycle rr_ptr updates: arbitration uses the updated pointer.
- Output stall in LOCKED (ready_out=0): lock is held and no beat is lost.
- Skid buffer full: ready_in=0 for the whole group.
- Reset asserted mid-packet: lock is dropped and buffer contents are discarded. Upstream is reset concurrently.
- Groups are fully independent; there is no cross-group interaction.

## Configuration
- STREAM_PKT_ARB_PERF_EN defined:
  - perf_pkts_out increments on each output handshake with last_out=1.
  - perf_stalls increments on each cycle with valid_out=1 and ready_out=0.
  - Both counters wrap modulo 2^PERF_CTR_W and clear on reset.
- Not defined: both perf ports and their counters are absent, and there is zero area cost.

## Test plan
- Single group, N=4, M=1, OUT_BUF=0, all inputs valid with single-beat packets, ready_out=1 → sel_out sequence 0,1,2,3,0, one beat per cycle.
- Input 1 sends a 3-beat packet while input 0/2 are valid → sel_out=1 for exactly 3 beats, then grant moves to 2; inputs 0/2 see ready_in=0 throughout.
- Locked input 1 deasserts valid for 2 cycles mid-packet → valid_out=0 for those 2 cycles, no other input granted, packet resumes intact.
- OUT_BUF=1, ready_out toggles 1,0,1,0 on a 4-beat stream → all 4 beats delivered in order, latency 1 cycle, no drop or duplicate; ready_in is never combinationally affected by ready_out.
- N=6, M=2: inputs 0 and 3 each send 2-beat packets simultaneously → both outputs forward concurrently, with sel_out[0]=0 and sel_out[1]=0.
- Reset pulse during beat 2 of a 4-beat packet, with the perf macro defined → valid_out=0, perf counters=0 next cycle; first post-reset grant goes to input 0.
